// File: rtl/imem_loader.sv
// Boot loader that streams a word-counted image into byte-wide instruction memory
// and holds the CPU in reset until the image is in place. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] HDR_HI = 3'd0;
  localparam logic [2:0] HDR_LO = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM        = 3'd3;
  localparam logic [2:0] PAYLOAD_END = CSUM;
`else
  localparam logic [2:0] PAYLOAD_END = DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'(MEM_BYTES / 4);

  logic [2:0]        state_q, state_d;
  logic [7:0]        n_hi_q, n_hi_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              cpu_reset_q, cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] hdr_n;
  logic        last_byte;

  assign s_ready   = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_q == CSUM)
`endif
                     ;
  assign xfer      = s_valid && s_ready;
  assign hdr_n     = {n_hi_q, s_data};
  // Byte index k is the last one when k+1 == 4*N; done in 32 bits so no width is lost.
  assign last_byte = ((32'(byte_cnt_q) + 32'd1) == {14'd0, n_q, 2'b00});

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERROR);

  always_comb begin
    state_d     = state_q;
    n_hi_d      = n_hi_q;
    n_d         = n_q;
    byte_cnt_d  = byte_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_reset_d = cpu_reset_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      HDR_HI: begin
        if (xfer) begin
          n_hi_d  = s_data;
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          n_d        = hdr_n;
          byte_cnt_d = '0;
          if (hdr_n == 16'd0) begin
            state_d = PAYLOAD_END;
          end else if ({1'b0, hdr_n} > MAX_WORDS) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = byte_cnt_q;
          wr_data_d  = s_data;
          byte_cnt_d = byte_cnt_q + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ s_data;
`endif
          if (last_byte) begin
            state_d = PAYLOAD_END;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          state_d = (s_data == csum_q) ? DONE : ERROR;
        end
      end
`endif
      DONE, ERROR: begin
        // The CPU is released only after a full cycle in DONE, so the last write has landed.
        if (state_q == DONE) begin
          cpu_reset_d = 1'b0;
        end
        if (start) begin
          state_d     = HDR_HI;
          n_hi_d      = '0;
          n_d         = '0;
          byte_cnt_d  = '0;
          cpu_reset_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
        end
      end
      default: begin
        state_d = HDR_HI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HDR_HI;
      n_hi_q      <= '0;
      n_q         <= '0;
      byte_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_hi_q      <= n_hi_d;
      n_q         <= n_d;
      byte_cnt_q  <= byte_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues the write each payload byte must cause,
// and an independent monitor pops and checks every wr_en cycle against it.
module tb_imem_loader;
  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = MEM_BYTES / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  logic [7:0] payload[$];
  int         exp_addr_q[$];
  logic [7:0] exp_data_q[$];
  int         exp_cyc_q[$];
  logic [7:0] mem [0:MEM_BYTES-1];

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle_cnt++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every observed write must be the oldest outstanding expected write, one cycle after its transfer.
  initial begin
    int a;
    int c;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        mem[wr_addr] = wr_data;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
        end else begin
          a = exp_addr_q.pop_front();
          d = exp_data_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("wr_addr", 32'(wr_addr), a);
          check("wr_data", 32'(wr_data), 32'(d));
          check("wr_cycle", cycle_cnt, c);
        end
      end
    end
  end

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic maybe_gap(input int pct, input int gmin, input int gmax);
    if (pct > 0 && int'($urandom_range(0, 99)) < pct) idle(int'($urandom_range(gmin, gmax)));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_payload, input int addr, input logic st);
    check("s_ready_accepting", s_ready, 1'b1);
    s_valid = 1'b1;
    s_data  = b;
    start   = st;
    if (is_payload) begin
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(b);
      exp_cyc_q.push_back(cycle_cnt + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_output(input logic ok, input int nbytes);
    int bad;
    check("done_end", done, ok);
    check("error_end", error, !ok);
    check("s_ready_end", s_ready, 1'b0);
    check("cpu_reset_held", cpu_reset, 1'b1);
    @(negedge clk);
    check("cpu_reset_after", cpu_reset, !ok);
    check("done_stable", done, ok);
    check("pending_writes", exp_addr_q.size(), 0);
    bad = 0;
    for (int i = 0; i < nbytes; i++) if (mem[i] !== payload[i]) bad++;
    check("mem_contents_bad", bad, 0);
  endtask

  task automatic apply_stimulus(input int n, input int gap_pct, input int gmin, input int gmax,
                                input logic bad_csum, input logic rand_start);
    logic ok;
    logic [7:0] x;
    logic [15:0] nw;
    nw = 16'(n);
    ok = (n <= MAX_WORDS);
    x  = 8'h00;
    maybe_gap(gap_pct, gmin, gmax);
    send_byte(nw[15:8], 1'b0, 0, rand_start && ($urandom_range(0, 9) == 0));
    maybe_gap(gap_pct, gmin, gmax);
    send_byte(nw[7:0], 1'b0, 0, rand_start && ($urandom_range(0, 9) == 0));
    if (ok) begin
      for (int k = 0; k < 4 * n; k++) begin
        maybe_gap(gap_pct, gmin, gmax);
        send_byte(payload[k], 1'b1, k, rand_start && ($urandom_range(0, 9) == 0));
        x = x ^ payload[k];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      maybe_gap(gap_pct, gmin, gmax);
      send_byte(x ^ {7'd0, bad_csum}, 1'b0, 0, 1'b0);
      ok = !bad_csum;
`else
      if (bad_csum) $display("[TB] checksum disabled; corruption of %02h not sent", x);
`endif
    end
    s_valid = 1'b0;
    check_output(ok, (n <= MAX_WORDS) ? 4 * n : 0);
  endtask

  task automatic rearm();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rearm_done", done, 1'b0);
    check("rearm_error", error, 1'b0);
    check("rearm_cpu_reset", cpu_reset, 1'b1);
    check("rearm_s_ready", s_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_pending", exp_addr_q.size(), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_random(input int n);
    payload.delete();
    for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int n;
    int r;
    logic bad;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    @(negedge clk);
    do_reset();

    payload = '{8'h3C, 8'h08, 8'h00, 8'h10, 8'h35, 8'h08, 8'h00, 8'h04};
    apply_stimulus(2, 0, 0, 0, 1'b0, 1'b0);
    rearm();

    payload.delete();
    apply_stimulus(0, 0, 0, 0, 1'b0, 1'b0);
    rearm();

    payload.delete();
    apply_stimulus(16'h0101, 0, 0, 0, 1'b0, 1'b0);
    idle(3);
    check("error_holds", error, 1'b1);
    check("error_cpu_reset", cpu_reset, 1'b1);
    rearm();

    fill_random(1);
    apply_stimulus(1, 100, 2, 2, 1'b0, 1'b0);
    rearm();

    fill_random(1);
    send_byte(8'h00, 1'b0, 0, 1'b0);
    send_byte(8'h01, 1'b0, 0, 1'b0);
    send_byte(payload[0], 1'b1, 0, 1'b0);
    send_byte(payload[1], 1'b1, 1, 1'b0);
    idle(1);
    do_reset();
    fill_random(1);
    apply_stimulus(1, 0, 0, 0, 1'b0, 1'b0);
    rearm();

`ifdef IMEM_LOADER_CHECKSUM_EN
    payload = '{8'h12, 8'h34, 8'h56, 8'h78};
    apply_stimulus(1, 0, 0, 0, 1'b0, 1'b0);
    rearm();
    apply_stimulus(1, 0, 0, 0, 1'b1, 1'b0);
    rearm();
`endif

    fill_random(MAX_WORDS);
    apply_stimulus(MAX_WORDS, 0, 0, 0, 1'b0, 1'b0);
    rearm();

    for (int it = 0; it < 25; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) n = int'($urandom_range(MAX_WORDS + 1, 65535));
      else if (r == 1) n = 0;
      else n = int'($urandom_range(1, 8));
`ifdef IMEM_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      if (n <= MAX_WORDS) fill_random(n);
      else payload.delete();
      apply_stimulus(n, 30, 1, 3, bad, 1'b1);
      rearm();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
